video_stream_rx: RTL and testbench



---
 rtl/video_stream_rx_pkg.sv | 12 +
 rtl/video_sync_edge.sv | 36 +++
 rtl/video_stream_rx.sv | 141 ++++++++++++++
 tb/tb_video_stream_rx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_rx_pkg.sv
// Shared types and constants for the video_stream_rx receive path.
package video_stream_rx_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned CNT_W_DEF   = 12;

endpackage

// File: rtl/video_sync_edge.sv
// Two-stage capture of the sync/enable lines with frame-start and line-end edge detect.
module video_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic de,
  input  logic vsync,
  input  logic hsync,
  output logic de_s1,
  output logic de_s2,
  output logic vsync_s1,
  output logic vsync_s2,
  output logic hsync_s1,
  output logic vs_rise,
  output logic de_fall
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_s1    <= 1'b0;
      de_s2    <= 1'b0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      hsync_s1 <= 1'b0;
    end else begin
      de_s1    <= de;
      de_s2    <= de_s1;
      vsync_s1 <= vsync;
      vsync_s2 <= vsync_s1;
      hsync_s1 <= hsync;
    end
  end

  assign vs_rise = vsync_s1 & ~vsync_s2;
  assign de_fall = de_s2 & ~de_s1;

endmodule

// File: rtl/video_stream_rx.sv
// Parallel rgb/de/vsync receiver: framed pixel stream with SOF/EOL plus frame geometry check.
module video_stream_rx
  import video_stream_rx_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      rgb,
  input  logic                   de,
  input  logic                   vsync,
  input  logic                   hsync,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic [CNT_W-1:0]       meas_h,
  output logic [CNT_W-1:0]       meas_v,
  output logic                   meas_valid,
  output logic                   err_h,
  output logic                   err_v,
  output logic                   locked,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_next;

  logic [DATA_W-1:0] rgb_s1;
  logic de_s1, de_s2, vsync_s1, vsync_s2, hsync_s1_unused, vs_rise, de_fall;

  logic             drop, sof_pend, h_err;
  logic [CNT_W-1:0] pix_cnt, line_cnt, last_len;

  logic             in_frame, fwd, line_end, close, h_bad, h_err_next, err_v_next;
  logic [CNT_W-1:0] line_cnt_next, last_len_next;

  video_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .de       (de),
    .vsync    (vsync),
    .hsync    (hsync),
    .de_s1    (de_s1),
    .de_s2    (de_s2),
    .vsync_s1 (vsync_s1),
    .vsync_s2 (vsync_s2),
    .hsync_s1 (hsync_s1_unused),
    .vs_rise  (vs_rise),
    .de_fall  (de_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (vs_rise) state_next = S_FRAME;
  end

  // A vsync edge inside a de burst ends the line at the stage-2 pixel; the
  // stage-1 pixel and the rest of that burst belong to no frame and are dropped.
  always_comb begin
    in_frame      = (state == S_FRAME);
    fwd           = de_s1 & (vs_rise ? ~de_s2 : (in_frame & ~drop));
    line_end      = in_frame & ~drop & (de_fall | (vs_rise & de_s1 & de_s2));
    close         = in_frame & vs_rise;
    h_bad         = (pix_cnt != H_EXP) | (pix_cnt == CNT_MAX);
    h_err_next    = h_err | (line_end & h_bad);
    line_cnt_next = (line_end && line_cnt != CNT_MAX) ? line_cnt + 1'b1 : line_cnt;
    last_len_next = line_end ? pix_cnt : last_len;
    err_v_next    = (line_cnt_next != V_EXP) | (line_cnt_next == CNT_MAX);
  end

  assign m_eol = m_valid & (~de_s1 | vs_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_s1     <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      meas_valid <= 1'b0;
      drop       <= 1'b0;
      sof_pend   <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      last_len   <= '0;
      h_err      <= 1'b0;
      meas_h     <= '0;
      meas_v     <= '0;
      err_h      <= 1'b0;
      err_v      <= 1'b0;
      locked     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      rgb_s1     <= rgb;
      m_valid    <= fwd;
      m_sof      <= fwd & (sof_pend | vs_rise);
      meas_valid <= close;
      if (fwd) m_data <= rgb_s1;

      if (vs_rise) begin
        pix_cnt  <= fwd ? CNT_W'(1) : '0;
        line_cnt <= '0;
        last_len <= '0;
        h_err    <= 1'b0;
        drop     <= de_s1 & de_s2;
        sof_pend <= ~fwd;
      end else begin
        line_cnt <= line_cnt_next;
        last_len <= last_len_next;
        h_err    <= h_err_next;
        if (!de_s1) drop <= 1'b0;
        if (fwd) sof_pend <= 1'b0;
        if (line_end)                          pix_cnt <= '0;
        else if (fwd && pix_cnt != CNT_MAX)    pix_cnt <= pix_cnt + 1'b1;
      end

      // Close uses the post-line-accounting values so a line ending on the
      // same cycle as vsync is part of the frame being closed.
      if (close) begin
        meas_h    <= last_len_next;
        meas_v    <= line_cnt_next;
        err_h     <= h_err_next;
        err_v     <= err_v_next;
        locked    <= ~(h_err_next | err_v_next);
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_rx.sv
// Randomized frame-level stimulus against a transaction-level model of the receiver.
module tb_video_stream_rx;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned SAT = 4095;

  logic        clk, rst;
  logic [23:0] rgb;
  logic        de, vsync, hsync;
  logic [23:0] m_data;
  logic        m_valid, m_sof, m_eol;
  logic [11:0] meas_h, meas_v;
  logic        meas_valid, err_h, err_v, locked;
  logic [15:0] frame_cnt;

  video_stream_rx #(.DATA_W(24), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .rgb(rgb), .de(de), .vsync(vsync), .hsync(hsync),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol),
    .meas_h(meas_h), .meas_v(meas_v), .meas_valid(meas_valid),
    .err_h(err_h), .err_v(err_v), .locked(locked), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eol;
    logic [31:0] cyc;
  } px_t;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        eh;
    logic        ev;
    logic        lk;
    logic [15:0] fc;
    logic [31:0] cyc;
  } ms_t;

  px_t pq[$];
  ms_t mq[$];

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  // Model state: frame open?, SOF owed, lines / h-error / last length of open frame
  bit          mo_open = 0;
  bit          mo_sof  = 0;
  int unsigned mo_lines = 0;
  bit          mo_herr = 0;
  int unsigned mo_last = 0;
  logic [15:0] mo_fc = '0;
  bit          px_override = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        if (pq.size() == 0) check("unexpected_m_valid", 32'(m_valid), 32'd0);
        else begin
          px_t e;
          e = pq.pop_front();
          check("m_data", 32'(m_data), 32'(e.d));
          check("m_sof",  32'(m_sof),  32'(e.sof));
          check("m_eol",  32'(m_eol),  32'(e.eol));
          check("px_latency_cycle", cyc, e.cyc);
        end
      end
      if (meas_valid) begin
        if (mq.size() == 0) check("unexpected_meas_valid", 32'(meas_valid), 32'd0);
        else begin
          ms_t e;
          e = mq.pop_front();
          check("meas_h",    32'(meas_h),    32'(e.h));
          check("meas_v",    32'(meas_v),    32'(e.v));
          check("err_h",     32'(err_h),     32'(e.eh));
          check("err_v",     32'(err_v),     32'(e.ev));
          check("locked",    32'(locked),    32'(e.lk));
          check("frame_cnt", 32'(frame_cnt), 32'(e.fc));
          check("meas_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic d, input logic v, input logic [23:0] px);
    de    = d;
    vsync = v;
    rgb   = px;
    hsync = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] next_px();
    logic [23:0] p;
    p = 24'($urandom);
    if (px_override) begin
      p = 24'h123456;
      px_override = 0;
    end
    return p;
  endfunction

  task automatic frame_boundary();
    if (mo_open) begin
      ms_t m;
      mo_fc  = mo_fc + 16'd1;
      m.h    = 12'(mo_last);
      m.v    = 12'(mo_lines);
      m.eh   = mo_herr;
      m.ev   = (mo_lines != V);
      m.lk   = !(mo_herr || mo_lines != V);
      m.fc   = mo_fc;
      m.cyc  = cyc + 2;
      mq.push_back(m);
    end
    mo_open  = 1;
    mo_sof   = 1;
    mo_lines = 0;
    mo_herr  = 0;
    mo_last  = 0;
  endtask

  task automatic account_line(input int unsigned len);
    if (mo_open) begin
      mo_lines++;
      if (len != H || len >= SAT) mo_herr = 1;
      mo_last = (len > SAT) ? SAT : len;
    end
  endtask

  task automatic send_line(input int unsigned len, input int unsigned hb);
    for (int unsigned i = 0; i < len; i++) begin
      logic [23:0] p;
      p = next_px();
      if (mo_open) begin
        pq.push_back('{d: p, sof: mo_sof, eol: (i == len - 1), cyc: cyc + 2});
        mo_sof = 0;
      end
      drive(1'b1, 1'b0, p);
    end
    account_line(len);
    for (int unsigned i = 0; i < hb; i++) drive(1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic send_vsync();
    frame_boundary();
    drive(1'b0, 1'b1, 24'($urandom));
    drive(1'b0, 1'b1, 24'($urandom));
    drive(1'b0, 1'b0, 24'($urandom));
    drive(1'b0, 1'b0, 24'($urandom));
  endtask

  // vsync rises while de is high after k pixels; m further pixels follow in that burst
  task automatic send_cut_line(input int unsigned k, input int unsigned m);
    for (int unsigned i = 0; i < k; i++) begin
      logic [23:0] p;
      p = next_px();
      if (mo_open) begin
        pq.push_back('{d: p, sof: mo_sof, eol: (i == k - 1), cyc: cyc + 2});
        mo_sof = 0;
      end
      drive(1'b1, 1'b0, p);
    end
    account_line(k);
    frame_boundary();
    for (int unsigned i = 0; i < m; i++) drive(1'b1, 1'b1, 24'($urandom));
    drive(1'b0, 1'b1, 24'($urandom));
    drive(1'b0, 1'b0, 24'($urandom));
    drive(1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic send_frame(input int unsigned nl, input int unsigned bad, input int unsigned blen);
    for (int unsigned i = 0; i < nl; i++) begin
      int unsigned len, hb;
      len = (i == bad) ? blen : H;
      hb  = (i == nl - 1) ? $urandom_range(0, 3) : $urandom_range(1, 4);
      send_line(len, hb);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"},    32'(m_valid),    32'd0);
    check({tag, "_m_data"},     32'(m_data),     32'd0);
    check({tag, "_m_sof"},      32'(m_sof),      32'd0);
    check({tag, "_m_eol"},      32'(m_eol),      32'd0);
    check({tag, "_meas_h"},     32'(meas_h),     32'd0);
    check({tag, "_meas_v"},     32'(meas_v),     32'd0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_err_h"},      32'(err_h),      32'd0);
    check({tag, "_err_v"},      32'(err_v),      32'd0);
    check({tag, "_locked"},     32'(locked),     32'd0);
    check({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: sim time %0t exceeded bound", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; de = 1'b0; vsync = 1'b0; hsync = 1'b0; rgb = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);

    // Pixels before the first vsync are dropped; first vsync only opens a frame
    send_line(20, 3);
    send_vsync();
    check("frame_cnt_after_first_vs", 32'(frame_cnt), 32'd0);

    // Nominal frames; first pixel carries a known value
    px_override = 1;
    send_frame(V, 99, 0);
    send_vsync();
    send_frame(V, 99, 0);
    send_vsync();
    check("frame_cnt_after_third_vs", 32'(frame_cnt), 32'd2);
    check("locked_nominal", 32'(locked), 32'd1);

    // Short line, then clean recovery; extra line
    send_frame(V, 1, 7);
    send_vsync();
    check("err_h_short_line", 32'(err_h), 32'd1);
    send_frame(V, 99, 0);
    send_vsync();
    check("locked_recovered", 32'(locked), 32'd1);
    send_frame(V + 1, 99, 0);
    send_vsync();
    check("meas_v_extra_line", 32'(meas_v), 32'd5);

    // Randomized geometry
    for (int f = 0; f < 10; f++) begin
      int unsigned nl, bad, blen;
      nl   = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 5) : V;
      bad  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nl - 1) : 99;
      blen = $urandom_range(1, 7) + (($urandom_range(0, 1) == 1) ? 2 : 0);
      send_frame(nl, bad, blen);
      send_vsync();
    end

    // vsync inside a de burst after 3 pixels, then a clean frame
    send_frame(2, 99, 0);
    send_cut_line(3, 4);
    send_frame(V, 99, 0);
    send_vsync();
    check("locked_after_cut_recovery", 32'(locked), 32'd1);

    // Pixel counter saturation on the last line of a frame
    send_frame(V - 1, 99, 0);
    send_line(4100, 0);
    send_vsync();

    // Asynchronous reset mid-line
    send_line(H, 2);
    for (int i = 0; i < 4; i++) begin
      logic [23:0] p;
      p = next_px();
      pq.push_back('{d: p, sof: 1'b0, eol: 1'b0, cyc: cyc + 2});
      drive(1'b1, 1'b0, p);
    end
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    pq.delete();
    mq.delete();
    mo_open = 0;
    mo_fc   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_line(4, 3);
    send_frame(V, 99, 0);
    send_vsync();
    check("frame_cnt_after_reset_vs", 32'(frame_cnt), 32'd0);
    send_frame(V, 99, 0);
    send_vsync();

    repeat (4) drive(1'b0, 1'b0, '0);
    check("pixel_queue_drained", 32'(pq.size()), 32'd0);
    check("meas_queue_drained",  32'(mq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
